// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester AXI4-Lite memory arbiter:
//   - arb_state_t      : transaction state machine encoding
//   - PROT             : fixed AXI protection attribute driven on awprot/arprot
//   - DEFAULT_ERR_WORD : read data returned when the slave watchdog fires
//   - GRANT_*          : one-hot grant encodings (bit 0 = m0, bit 1 = m1)
//   - is_write()       : a request with any byte strobe set is a write
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AR   = 3'd1,
      ST_R    = 3'd2,
      ST_AW_W = 3'd3,
      ST_B    = 3'd4,
      ST_DONE = 3'd5
   } arb_state_t;

   localparam logic [2:0]  PROT             = 3'b000;
   localparam logic [31:0] DEFAULT_ERR_WORD = 32'hDEAD_BEEF;

   localparam logic [1:0]  GRANT_NONE = 2'b00;
   localparam logic [1:0]  GRANT_M0   = 2'b01;
   localparam logic [1:0]  GRANT_M1   = 2'b10;

   function automatic logic is_write(input logic [3:0] wstrb);
      return (wstrb != 4'b0000);
   endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr
// Two-way round-robin picker. Purely combinational; the caller registers the
// result and owns the last-grant state.
// Ports:
//   valid      in  2  request lines, bit 0 = m0, bit 1 = m1
//   last_grant in  2  one-hot requester granted most recently
//   grant      out 2  one-hot pick (00 when nobody requests)
// -----------------------------------------------------------------------------
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic [1:0] last_grant,
   output logic [1:0] grant
);

   // Pick the single requester, or on a tie the one not served last.
   always_comb begin
      grant = GRANT_NONE;
      case (valid)
         2'b01: grant = GRANT_M0;
         2'b10: grant = GRANT_M1;
         2'b11: begin
            if (last_grant == GRANT_M0) begin
               grant = GRANT_M1;
            end else begin
               grant = GRANT_M0;
            end
         end
         default: grant = GRANT_NONE;
      endcase
   end

endmodule

// File: rtl/mem_axi_arbiter.sv
// -----------------------------------------------------------------------------
// mem_axi_arbiter
// Arbitrates two simple valid/ready memory requesters (m0 = core, m1 = host
// bridge) onto one AXI4-Lite master port, one transaction at a time. A
// watchdog aborts any transaction whose slave stalls for TIMEOUT cycles and
// returns ERR_WORD with a timeout_err pulse.
// Parameters:
//   TIMEOUT   watchdog limit in clk cycles (2..65535)
//   ERR_WORD  read data returned on a watchdog abort
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   m0_* / m1_*                 requester: valid/addr/wdata/wstrb in,
//                               ready (1-cycle pulse) / rdata out
//   mem_axi_*                   AXI4-Lite master (AW, W, B, AR, R channels)
//   grant                       one-hot current bus owner, 00 when idle
//   timeout_err                 pulses with ready of an aborted transaction
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mem_axi_arbiter
   import mem_arb_pkg::*;
#(
   parameter int          TIMEOUT  = 1024,
   parameter logic [31:0] ERR_WORD = DEFAULT_ERR_WORD
)(
   input  logic        clk,
   input  logic        resetn,

   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,

   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,

   output logic        mem_axi_awvalid,
   input  logic        mem_axi_awready,
   output logic [31:0] mem_axi_awaddr,
   output logic [2:0]  mem_axi_awprot,

   output logic        mem_axi_wvalid,
   input  logic        mem_axi_wready,
   output logic [31:0] mem_axi_wdata,
   output logic [3:0]  mem_axi_wstrb,

   input  logic        mem_axi_bvalid,
   output logic        mem_axi_bready,

   output logic        mem_axi_arvalid,
   input  logic        mem_axi_arready,
   output logic [31:0] mem_axi_araddr,
   output logic [2:0]  mem_axi_arprot,

   input  logic        mem_axi_rvalid,
   output logic        mem_axi_rready,
   input  logic [31:0] mem_axi_rdata,

   output logic [1:0]  grant,
   output logic        timeout_err
);

   // Watchdog fires when the counter reaches TIMEOUT-1, i.e. on the
   // TIMEOUT-th busy cycle of the transaction.
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   arb_state_t  state_r;
   logic [1:0]  last_grant_r;
   logic [15:0] wd_cnt_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;

   logic [1:0]  pick_s;
   logic [31:0] req_addr_s;
   logic [31:0] req_wdata_s;
   logic [3:0]  req_wstrb_s;
   logic        busy_s;
   logic        done_ok_s;
   logic        wd_expired_s;
   logic        timeout_s;
   logic        aw_done_s;
   logic        w_done_s;

   mem_arb_rr u_rr (
      .valid      ({m1_valid, m0_valid}),
      .last_grant (last_grant_r),
      .grant      (pick_s)
   );

   // Request fields of whichever requester the picker chose.
   always_comb begin
      req_addr_s  = m0_addr;
      req_wdata_s = m0_wdata;
      req_wstrb_s = m0_wstrb;
      if (pick_s == GRANT_M1) begin
         req_addr_s  = m1_addr;
         req_wdata_s = m1_wdata;
         req_wstrb_s = m1_wstrb;
      end else begin
         req_addr_s  = m0_addr;
         req_wdata_s = m0_wdata;
         req_wstrb_s = m0_wstrb;
      end
   end

   // Classify the current state: busy (watchdog counting) and whether the
   // final slave response is being accepted this cycle.
   always_comb begin
      busy_s    = 1'b0;
      done_ok_s = 1'b0;
      case (state_r)
         ST_AR, ST_AW_W: begin
            busy_s    = 1'b1;
            done_ok_s = 1'b0;
         end
         ST_R: begin
            busy_s    = 1'b1;
            done_ok_s = mem_axi_rvalid;
         end
         ST_B: begin
            busy_s    = 1'b1;
            done_ok_s = mem_axi_bvalid;
         end
         default: begin
            busy_s    = 1'b0;
            done_ok_s = 1'b0;
         end
      endcase
   end

   // A real response arriving on the last watchdog cycle wins over the abort.
   assign wd_expired_s = (wd_cnt_r == WD_LAST);
   assign timeout_s    = busy_s && wd_expired_s && !done_ok_s;

   // AW and W complete independently; a channel is done once its valid is low.
   assign aw_done_s = !mem_axi_awvalid || mem_axi_awready;
   assign w_done_s  = !mem_axi_wvalid  || mem_axi_wready;

   assign mem_axi_awaddr = addr_r;
   assign mem_axi_araddr = addr_r;
   assign mem_axi_wdata  = wdata_r;
   assign mem_axi_wstrb  = wstrb_r;
   assign mem_axi_awprot = PROT;
   assign mem_axi_arprot = PROT;

   // Transaction state machine with all handshake outputs registered.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r         <= ST_IDLE;
         grant           <= GRANT_NONE;
         last_grant_r    <= GRANT_M1;
         wd_cnt_r        <= 16'd0;
         addr_r          <= 32'h0000_0000;
         wdata_r         <= 32'h0000_0000;
         wstrb_r         <= 4'b0000;
         mem_axi_awvalid <= 1'b0;
         mem_axi_wvalid  <= 1'b0;
         mem_axi_bready  <= 1'b0;
         mem_axi_arvalid <= 1'b0;
         mem_axi_rready  <= 1'b0;
         m0_ready        <= 1'b0;
         m1_ready        <= 1'b0;
         m0_rdata        <= 32'h0000_0000;
         m1_rdata        <= 32'h0000_0000;
         timeout_err     <= 1'b0;
      end else begin
         m0_ready    <= 1'b0;
         m1_ready    <= 1'b0;
         timeout_err <= 1'b0;

         if (timeout_s) begin
            // Abandon the slave: drop every valid/ready and report the error.
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            wd_cnt_r        <= 16'd0;
            m0_ready        <= grant[0];
            m1_ready        <= grant[1];
            timeout_err     <= 1'b1;
            if (grant[1]) begin
               m1_rdata <= ERR_WORD;
            end else begin
               m0_rdata <= ERR_WORD;
            end
            state_r <= ST_DONE;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  wd_cnt_r <= 16'd0;
                  if (pick_s != GRANT_NONE) begin
                     grant        <= pick_s;
                     last_grant_r <= pick_s;
                     addr_r       <= req_addr_s;
                     wdata_r      <= req_wdata_s;
                     wstrb_r      <= req_wstrb_s;
                     if (is_write(req_wstrb_s)) begin
                        mem_axi_awvalid <= 1'b1;
                        mem_axi_wvalid  <= 1'b1;
                        state_r         <= ST_AW_W;
                     end else begin
                        mem_axi_arvalid <= 1'b1;
                        state_r         <= ST_AR;
                     end
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end

               ST_AR: begin
                  wd_cnt_r <= wd_cnt_r + 16'd1;
                  if (mem_axi_arready) begin
                     mem_axi_arvalid <= 1'b0;
                     mem_axi_rready  <= 1'b1;
                     state_r         <= ST_R;
                  end else begin
                     state_r <= ST_AR;
                  end
               end

               ST_R: begin
                  if (mem_axi_rvalid) begin
                     mem_axi_rready <= 1'b0;
                     wd_cnt_r       <= 16'd0;
                     m0_ready       <= grant[0];
                     m1_ready       <= grant[1];
                     if (grant[1]) begin
                        m1_rdata <= mem_axi_rdata;
                     end else begin
                        m0_rdata <= mem_axi_rdata;
                     end
                     state_r <= ST_DONE;
                  end else begin
                     wd_cnt_r <= wd_cnt_r + 16'd1;
                     state_r  <= ST_R;
                  end
               end

               ST_AW_W: begin
                  wd_cnt_r <= wd_cnt_r + 16'd1;
                  if (mem_axi_awvalid && mem_axi_awready) begin
                     mem_axi_awvalid <= 1'b0;
                  end else begin
                     mem_axi_awvalid <= mem_axi_awvalid;
                  end
                  if (mem_axi_wvalid && mem_axi_wready) begin
                     mem_axi_wvalid <= 1'b0;
                  end else begin
                     mem_axi_wvalid <= mem_axi_wvalid;
                  end
                  if (aw_done_s && w_done_s) begin
                     mem_axi_bready <= 1'b1;
                     state_r        <= ST_B;
                  end else begin
                     state_r <= ST_AW_W;
                  end
               end

               ST_B: begin
                  if (mem_axi_bvalid) begin
                     mem_axi_bready <= 1'b0;
                     wd_cnt_r       <= 16'd0;
                     m0_ready       <= grant[0];
                     m1_ready       <= grant[1];
                     state_r        <= ST_DONE;
                  end else begin
                     wd_cnt_r <= wd_cnt_r + 16'd1;
                     state_r  <= ST_B;
                  end
               end

               ST_DONE: begin
                  // Ready pulses this cycle; IDLE looks at valids only after
                  // the requester has seen it.
                  grant    <= GRANT_NONE;
                  wd_cnt_r <= 16'd0;
                  state_r  <= ST_IDLE;
               end

               default: begin
                  grant           <= GRANT_NONE;
                  wd_cnt_r        <= 16'd0;
                  mem_axi_awvalid <= 1'b0;
                  mem_axi_wvalid  <= 1'b0;
                  mem_axi_bready  <= 1'b0;
                  mem_axi_arvalid <= 1'b0;
                  mem_axi_rready  <= 1'b0;
                  state_r         <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_axi_arbiter.sv
module tb_mem_axi_arbiter;

   logic        clk;
   logic        resetn;
   logic        m0_valid, m1_valid;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_axi_awvalid, mem_axi_awready;
   logic [31:0] mem_axi_awaddr;
   logic [2:0]  mem_axi_awprot;
   logic        mem_axi_wvalid, mem_axi_wready;
   logic [31:0] mem_axi_wdata;
   logic [3:0]  mem_axi_wstrb;
   logic        mem_axi_bvalid, mem_axi_bready;
   logic        mem_axi_arvalid, mem_axi_arready;
   logic [31:0] mem_axi_araddr;
   logic [2:0]  mem_axi_arprot;
   logic        mem_axi_rvalid, mem_axi_rready;
   logic [31:0] mem_axi_rdata;
   logic [1:0]  grant;
   logic        timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_axi_arbiter #(.TIMEOUT(8), .ERR_WORD(32'hDEAD_BEEF)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
      .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
      .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
      .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
      .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
      .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
      .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
      .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
      .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
      .mem_axi_rdata(mem_axi_rdata),
      .grant(grant), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- slave model ----------------
   int          w_wait = 0;
   logic        r_en   = 1'b1;
   logic        b_en   = 1'b1;
   logic [31:0] s_rdata = 32'h0;
   int          w_cnt;
   logic        aw_got, w_got;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;
   logic [2:0]  cap_awprot, cap_arprot;
   logic        aw_hs, w_hs, ar_hs;

   assign mem_axi_awready = 1'b1;
   assign mem_axi_arready = 1'b1;
   assign mem_axi_wready  = mem_axi_wvalid && (w_cnt >= w_wait);
   assign mem_axi_rdata   = s_rdata;
   assign aw_hs = mem_axi_awvalid && mem_axi_awready;
   assign w_hs  = mem_axi_wvalid && mem_axi_wready;
   assign ar_hs = mem_axi_arvalid && mem_axi_arready;

   // Registered slave responses: one cycle after the address/data handshakes.
   always @(posedge clk) begin
      if (!resetn) begin
         w_cnt          <= 0;
         aw_got         <= 1'b0;
         w_got          <= 1'b0;
         mem_axi_bvalid <= 1'b0;
         mem_axi_rvalid <= 1'b0;
      end else begin
         if (mem_axi_wvalid && !mem_axi_wready) w_cnt <= w_cnt + 1;
         else w_cnt <= 0;
         if (aw_hs) begin cap_awaddr <= mem_axi_awaddr; cap_awprot <= mem_axi_awprot; end
         if (w_hs)  begin cap_wdata <= mem_axi_wdata; cap_wstrb <= mem_axi_wstrb; end
         if (ar_hs) begin cap_araddr <= mem_axi_araddr; cap_arprot <= mem_axi_arprot; end
         if (mem_axi_bvalid && mem_axi_bready) begin
            mem_axi_bvalid <= 1'b0;
            aw_got         <= 1'b0;
            w_got          <= 1'b0;
         end else begin
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
            if ((aw_got || aw_hs) && (w_got || w_hs) && b_en) mem_axi_bvalid <= 1'b1;
         end
         if (mem_axi_rvalid && mem_axi_rready) mem_axi_rvalid <= 1'b0;
         else if (ar_hs && r_en) mem_axi_rvalid <= 1'b1;
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      m0_valid = 1'b0; m1_valid = 1'b0;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // Wait for either ready; cycle 0 is the first negedge after the call.
   task automatic wait_any(input int budget, output int who, output int lat);
      who = -1; lat = -1;
      for (int c = 0; c <= budget; c++) begin
         @(negedge clk);
         if (m0_ready) begin who = 0; lat = c; break; end
         else if (m1_ready) begin who = 1; lat = c; break; end
      end
   endtask

   task automatic drive(input int who, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb);
      if (who == 0) begin
         m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_valid = 1'b1;
      end else begin
         m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; m1_valid = 1'b1;
      end
   endtask

   typedef struct {
      int          who;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] srd;
      int          exp_lat;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [7];

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench stalled");
   end

   initial begin
      int who, lat, arv_cyc, rdy_cyc, aw_hi, w_hi, rdy_cnt;
      logic [1:0] gr1;
      logic [31:0] rd;
      m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;

      vecs[0] = '{0, 32'h0000_0200, 32'h0,         4'b0000, 32'hA5A5_0001, 3, 32'hA5A5_0001};
      vecs[1] = '{1, 32'h0000_0300, 32'h0,         4'b0000, 32'h0BAD_CAFE, 3, 32'h0BAD_CAFE};
      vecs[2] = '{0, 32'h0000_0204, 32'h1111_2222, 4'b1111, 32'h5555_5555, 3, 32'hA5A5_0001};
      vecs[3] = '{1, 32'hFFFF_FFFC, 32'h3333_4444, 4'b1000, 32'h6666_6666, 3, 32'h0BAD_CAFE};
      vecs[4] = '{1, 32'h8000_0000, 32'h0,         4'b0000, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF};
      vecs[5] = '{0, 32'h0000_0010, 32'h0000_00AA, 4'b0001, 32'h7777_7777, 3, 32'hA5A5_0001};
      vecs[6] = '{0, 32'h0000_0000, 32'h0,         4'b0000, 32'h0000_0000, 3, 32'h0000_0000};

      // ---- reset values ----
      apply_reset();
      @(negedge clk);
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_readys", {28'd0, m0_ready, m1_ready, timeout_err, 1'b0}, 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'h0);
      check("rst_m1_rdata", m1_rdata, 32'h0);
      check("rst_axi", {27'd0, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready,
                        mem_axi_arvalid, mem_axi_rready}, 32'd0);

      // ---- m0 read 0x100, zero-wait slave ----
      s_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      drive(0, 32'h0000_0100, 32'h0, 4'b0000);
      arv_cyc = -1; rdy_cyc = -1; gr1 = 2'b00; rd = 32'h0;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (arv_cyc < 0 && mem_axi_arvalid) arv_cyc = c;
         if (c == 1) gr1 = grant;
         if (m0_ready && rdy_cyc < 0) begin rdy_cyc = c; rd = m0_rdata; m0_valid = 1'b0; end
      end
      check("rd100_arvalid_cycle", arv_cyc, 32'd1);
      check("rd100_grant", {30'd0, gr1}, 32'd1);
      check("rd100_ready_cycle", rdy_cyc, 32'd3);
      check("rd100_rdata", rd, 32'h1234_5678);
      check("rd100_araddr", cap_araddr, 32'h0000_0100);

      // ---- table-driven single transactions ----
      for (int i = 0; i < 7; i++) begin
         s_rdata = vecs[i].srd;
         @(posedge clk); #1;
         drive(vecs[i].who, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
         wait_any(20, who, lat);
         check($sformatf("vec%0d_who", i), who, vecs[i].who);
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_rdata", i), (vecs[i].who == 0) ? m0_rdata : m1_rdata,
               vecs[i].exp_rdata);
         check($sformatf("vec%0d_grant", i), {30'd0, grant}, (vecs[i].who == 0) ? 32'd1 : 32'd2);
         check($sformatf("vec%0d_terr", i), {31'd0, timeout_err}, 32'd0);
         if (vecs[i].wstrb != 4'b0000) begin
            check($sformatf("vec%0d_awaddr", i), cap_awaddr, vecs[i].addr);
            check($sformatf("vec%0d_wdata", i), cap_wdata, vecs[i].wdata);
            check($sformatf("vec%0d_wstrb", i), {28'd0, cap_wstrb}, {28'd0, vecs[i].wstrb});
            check($sformatf("vec%0d_awprot", i), {29'd0, cap_awprot}, 32'd0);
         end else begin
            check($sformatf("vec%0d_araddr", i), cap_araddr, vecs[i].addr);
            check($sformatf("vec%0d_arprot", i), {29'd0, cap_arprot}, 32'd0);
         end
         m0_valid = 1'b0; m1_valid = 1'b0;
      end

      // ---- awready immediate, wready delayed 4 cycles ----
      w_wait = 4;
      @(posedge clk); #1;
      drive(0, 32'h0000_0500, 32'hCAFE_F00D, 4'b1111);
      aw_hi = 0; w_hi = 0; rdy_cnt = 0; rdy_cyc = -1;
      for (int c = 0; c <= 14; c++) begin
         @(negedge clk);
         aw_hi += int'(mem_axi_awvalid);
         w_hi  += int'(mem_axi_wvalid);
         if (m0_ready) begin rdy_cnt++; rdy_cyc = c; m0_valid = 1'b0; end
      end
      check("wdly_aw_cycles", aw_hi, 32'd1);
      check("wdly_w_cycles", w_hi, 32'd5);
      check("wdly_ready_pulses", rdy_cnt, 32'd1);
      check("wdly_ready_cycle", rdy_cyc, 32'd7);
      check("wdly_wdata", cap_wdata, 32'hCAFE_F00D);
      w_wait = 0;

      // ---- watchdog: slave never returns read data ----
      r_en = 1'b0;
      @(posedge clk); #1;
      drive(1, 32'h0000_0400, 32'h0, 4'b0000);
      wait_any(30, who, lat);
      check("wd_who", who, 32'd1);
      check("wd_lat", lat, 32'd9);
      check("wd_terr", {31'd0, timeout_err}, 32'd1);
      check("wd_rdata", m1_rdata, 32'hDEAD_BEEF);
      check("wd_rready", {31'd0, mem_axi_rready}, 32'd0);
      m1_valid = 1'b0;
      @(negedge clk);
      check("wd_idle_grant", {30'd0, grant}, 32'd0);
      check("wd_terr_pulse", {31'd0, timeout_err}, 32'd0);
      r_en = 1'b1;

      // ---- simultaneous writes from reset ----
      apply_reset();
      drive(0, 32'h0000_1000, 32'hAAAA_0000, 4'b1111);
      drive(1, 32'h0000_2000, 32'hBBBB_0000, 4'b0011);
      wait_any(20, who, lat);
      check("sim_first", who, 32'd0);
      check("sim_first_awaddr", cap_awaddr, 32'h0000_1000);
      check("sim_first_wdata", cap_wdata, 32'hAAAA_0000);
      m0_valid = 1'b0;
      wait_any(20, who, lat);
      check("sim_second", who, 32'd1);
      check("sim_second_awaddr", cap_awaddr, 32'h0000_2000);
      check("sim_second_wdata", cap_wdata, 32'hBBBB_0000);
      check("sim_second_wstrb", {28'd0, cap_wstrb}, 32'h3);
      m1_valid = 1'b0;

      // ---- both continuously valid: grants alternate ----
      apply_reset();
      drive(0, 32'h0000_3000, 32'h0, 4'b0000);
      drive(1, 32'h0000_4000, 32'h0, 4'b0000);
      for (int i = 0; i < 6; i++) begin
         wait_any(20, who, lat);
         check($sformatf("rr%0d_who", i), who, i % 2);
         check($sformatf("rr%0d_lat", i), lat, 32'd3);
      end
      m0_valid = 1'b0; m1_valid = 1'b0;
      @(negedge clk);

      // ---- reset during B ----
      b_en = 1'b0;
      @(posedge clk); #1;
      drive(0, 32'h0000_6000, 32'h1234_0000, 4'b1111);
      rdy_cnt = -1;
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (mem_axi_bready) begin rdy_cnt = c; break; end
      end
      check("rstb_bready_cycle", rdy_cnt, 32'd2);
      resetn = 1'b0; m0_valid = 1'b0;
      rdy_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (m0_ready || m1_ready) rdy_cnt++;
         if (c == 0) begin
            check("rstb_grant", {30'd0, grant}, 32'd0);
            check("rstb_axi", {27'd0, mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready,
                               mem_axi_arvalid, mem_axi_rready}, 32'd0);
            check("rstb_terr", {31'd0, timeout_err}, 32'd0);
            check("rstb_rdata", m0_rdata, 32'h0);
         end
      end
      check("rstb_no_ready", rdy_cnt, 32'd0);
      b_en = 1'b1;
      @(posedge clk); #1 resetn = 1'b1;
      drive(0, 32'h0000_7000, 32'h0, 4'b0000);
      drive(1, 32'h0000_8000, 32'h0, 4'b0000);
      wait_any(20, who, lat);
      check("rstb_next_first", who, 32'd0);
      m0_valid = 1'b0;
      wait_any(20, who, lat);
      check("rstb_next_second", who, 32'd1);
      m1_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_axi_arbiter.md
MEM_AXI_ARBITER -- requirements
Module: mem_axi_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: slave-response watchdog limit in clk cycles, legal range 2..65535.
REQ-002 SHALL have parameter ERR_WORD, default 32'hDEAD_BEEF: read data returned on timeout.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 m0_valid, m1_valid  in  1 each  requester holds request until its ready; m0 = core, m1 = host bridge.
REQ-006 m0_ready, m1_ready  out  1 each  one-cycle completion pulse.
REQ-007 m0_addr, m1_addr  in  32 each  byte address.
REQ-008 m0_wdata, m1_wdata  in  32 each  write data.
REQ-009 m0_wstrb, m1_wstrb  in  4 each  byte strobes; 0 = read.
REQ-010 m0_rdata, m1_rdata  out  32 each  read data, valid with ready.
REQ-011 mem_axi_awvalid/awaddr[32]/awprot[3] out, mem_axi_awready in: AXI4-Lite write address.
REQ-012 mem_axi_wvalid/wdata[32]/wstrb[4] out, mem_axi_wready in: write data.
REQ-013 mem_axi_bready out, mem_axi_bvalid in: write response.
REQ-014 mem_axi_arvalid/araddr[32]/arprot[3] out, mem_axi_arready in: read address.
REQ-015 mem_axi_rready out, mem_axi_rvalid/rdata[32] in: read data.
REQ-016 grant  out  2  one-hot owner of the bus (00 = idle).
REQ-017 timeout_err  out  1  one-cycle pulse with the ready of a timed-out transaction.

Function
REQ-018 States: IDLE, AR, R, AW_W, B, DONE; one transaction in flight at a time.
REQ-019 IDLE: if any valid, pick requester, latch addr/wdata/wstrb, set grant; go AW_W if wstrb!=0, else AR.
REQ-020 Arbitration round-robin: both valid -> grant the one not granted last; single valid -> grant it; last-grant updates on each grant.
REQ-021 AR: arvalid=1 until arready; then R. R: rready=1 until rvalid; capture rdata; then DONE.
REQ-022 AW_W: awvalid and wvalid asserted together; each drops independently after its own handshake; both done -> B.
REQ-023 B: bready=1 until bvalid; then DONE. bresp is not checked.
REQ-024 DONE: pulse ready of granted requester for exactly one cycle with registered rdata (writes: rdata holds last value); clear grant; next state IDLE.
REQ-025 Minimum latency with zero-wait slave: read valid at cycle 0 -> ready at cycle 3; write -> ready at cycle 3.
REQ-026 IDLE samples valid only the cycle after DONE, so a requester dropping valid on its ready edge is never re-issued.
REQ-027 All AXI outputs registered; AXI valids never depend combinationally on AXI readys.
REQ-028 prot = 3'b000 for m1, 3'b000 for m0 data, fixed; addresses passed unmodified.
REQ-029 Watchdog counts cycles in AR/R/AW_W/B; at TIMEOUT cycles force DONE, drop all AXI valids/readys, return ERR_WORD, pulse timeout_err.
REQ-030 Requester dropping valid mid-transaction: transaction still completes on AXI; ready still pulsed.

Reset
REQ-031 resetn low at any clock edge -> state IDLE, grant=00, all AXI valids/readys 0, m*_ready 0, timeout_err 0, rdata outputs 0, watchdog 0, last-grant = m1 (so m0 wins first tie).
REQ-032 Reset mid-transaction abandons it; no ready pulse; slave is reset by the same resetn.

Structure
REQ-033 Shared package mem_arb_pkg: state enumeration, PROT constant, default ERR_WORD.
REQ-034 Single sub-module mem_arb_rr: 2-way round-robin picker (valids + last-grant in, one-hot grant out).

Verification
REQ-035 m0 read addr 0x100, slave returns 0x1234_5678 zero-wait -> arvalid cycle 1, m0_ready cycle 3, m0_rdata 0x1234_5678.
REQ-036 m0 and m1 write simultaneously from reset -> m0 served first, then m1; awaddr/wdata/wstrb match each requester.
REQ-037 Both continuously valid for 6 transactions -> grants alternate m0,m1,m0,...
REQ-038 awready at cycle 1, wready delayed 4 cycles -> awvalid drops after cycle 1, wvalid held until wready, single ready pulse.
REQ-039 TIMEOUT=8, slave never asserts rvalid -> after 8 cycles ready+timeout_err pulse, rdata 0xDEAD_BEEF, rready low, IDLE.
REQ-040 resetn low during B -> next cycle all outputs at reset values, no ready pulse, next request m0 granted first.
